// File: rtl/fetch_mem_arbiter_if.sv
// Signal bundle between the fetch stage, the memory stage, the shared SRAM and
// the arbiter that multiplexes the two stages onto that SRAM.
//
// Handshake: a stage raises *_req and holds it until it sees its freeze output
// drop (or withdraws it). The arbiter drives sram_req for exactly one access at a
// time and keeps address/we/wdata stable until the SRAM answers with
// sram_ready=1 (sram_rdata is valid only in that cycle). An access that never
// sees sram_ready is aborted after TIMEOUT cycles.
interface fetch_mem_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [DATA_W-1:0] if_addr;
   logic              flush;
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              sram_ready;
   logic [DATA_W-1:0] sram_rdata;
   logic              sram_req;
   logic              sram_we;
   logic [DATA_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] if_inst;
   logic              if_freeze;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_freeze;
   logic              err;
   // Debug visibility: FSM state and the registered delivery pulses.
   logic [1:0]        dbg_state;
   logic              dbg_if_done;
   logic              dbg_mem_done;

   // Arbiter side.
   modport slave (
      input  if_req, if_addr, flush, mem_req, mem_we, mem_addr, mem_wdata,
             sram_ready, sram_rdata,
      output sram_req, sram_we, sram_addr, sram_wdata, if_inst, if_freeze,
             mem_rdata, mem_freeze, err, dbg_state, dbg_if_done, dbg_mem_done
   );

   // Pipeline / SRAM side.
   modport master (
      output if_req, if_addr, flush, mem_req, mem_we, mem_addr, mem_wdata,
             sram_ready, sram_rdata,
      input  sram_req, sram_we, sram_addr, sram_wdata, if_inst, if_freeze,
             mem_rdata, mem_freeze, err, dbg_state, dbg_if_done, dbg_mem_done
   );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Arbiter sharing one SRAM port between instruction fetch and data access.
// One access outstanding at a time, round-robin on ties, per-access timeout
// with a sticky error flag, and fetch discard on branch flush.
module fetch_mem_arbiter #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   fetch_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_ACC  = 2'd1,
      MEM_ACC = 2'd2
   } state_t;

   localparam logic       GRANT_FETCH = 1'b0;
   localparam logic       GRANT_MEM   = 1'b1;
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] if_inst_q, if_inst_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_done_q, if_done_d;
   logic              mem_done_q, mem_done_d;
   logic              discard_q, discard_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              err_q, err_d;

   logic              fetch_ok;
   logic              mem_ok;
   logic              timeout;
   logic              complete;
   logic [DATA_W-1:0] cap_data;

   // Next-state: grant in IDLE, complete or abort in an access state.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      if_inst_d    = if_inst_q;
      mem_rdata_d  = mem_rdata_q;
      if_done_d    = 1'b0;
      mem_done_d   = 1'b0;
      discard_d    = discard_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      timeout      = 1'b0;
      complete     = 1'b0;
      cap_data     = '0;
      // A requester whose done pulse is high is still looking at the old
      // result; granting it again would repeat the same access.
      fetch_ok     = bus.if_req && !bus.flush && !if_done_q;
      mem_ok       = bus.mem_req && !mem_done_q;

      case (state_q)
         IDLE: begin
            if (mem_ok && (!fetch_ok || last_grant_q == GRANT_FETCH)) begin
               state_d      = MEM_ACC;
               last_grant_d = GRANT_MEM;
               addr_d       = bus.mem_addr;
               we_d         = bus.mem_we;
               wdata_d      = bus.mem_wdata;
               cnt_d        = '0;
               discard_d    = 1'b0;
            end else if (fetch_ok) begin
               state_d      = IF_ACC;
               last_grant_d = GRANT_FETCH;
               addr_d       = bus.if_addr;
               we_d         = 1'b0;
               wdata_d      = '0;
               cnt_d        = '0;
               discard_d    = 1'b0;
            end
         end

         IF_ACC, MEM_ACC: begin
            timeout  = !bus.sram_ready && (cnt_q + 8'd1 == TIMEOUT_CNT);
            complete = bus.sram_ready || timeout;
            // An aborted access delivers zero as its data.
            cap_data = bus.sram_ready ? bus.sram_rdata : '0;
            if (!bus.sram_ready) begin
               cnt_d = cnt_q + 8'd1;
            end
            if (timeout) begin
               err_d = 1'b1;
            end
            if (state_q == IF_ACC && bus.flush) begin
               discard_d = 1'b1;
            end
            if (complete) begin
               state_d = IDLE;
               if (state_q == IF_ACC) begin
                  // A flush seen during this fetch (or with its completion)
                  // makes the fetched word stale: drop it silently.
                  if (!discard_q && !bus.flush) begin
                     if_inst_d = cap_data;
                     if_done_d = 1'b1;
                  end
               end else begin
                  mem_done_d = 1'b1;
                  if (!we_q) begin
                     mem_rdata_d = cap_data;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_FETCH;
         addr_q       <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         if_inst_q    <= '0;
         mem_rdata_q  <= '0;
         if_done_q    <= 1'b0;
         mem_done_q   <= 1'b0;
         discard_q    <= 1'b0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         if_inst_q    <= if_inst_d;
         mem_rdata_q  <= mem_rdata_d;
         if_done_q    <= if_done_d;
         mem_done_q   <= mem_done_d;
         discard_q    <= discard_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   assign bus.sram_req     = (state_q != IDLE);
   assign bus.sram_we      = (state_q == MEM_ACC) && we_q;
   assign bus.sram_addr    = addr_q;
   assign bus.sram_wdata   = wdata_q;
   assign bus.if_inst      = if_inst_q;
   assign bus.mem_rdata    = mem_rdata_q;
   assign bus.if_freeze    = bus.if_req && !if_done_q;
   assign bus.mem_freeze   = bus.mem_req && !mem_done_q;
   assign bus.err          = err_q;
   assign bus.dbg_state    = state_q;
   assign bus.dbg_if_done  = if_done_q;
   assign bus.dbg_mem_done = mem_done_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: random and directed accesses against a memory
// model; a monitor checks every delivery and every SRAM access.
module tb_fetch_mem_arbiter;
  localparam int W  = 32;
  localparam int TO = 15;

  typedef struct packed {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
  } acc_t;

  logic clk;
  logic rst;

  fetch_mem_arbiter_if #(.DATA_W(W)) bus ();

  fetch_mem_arbiter #(.DATA_W(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;

  logic [W-1:0] exp_if_q[$];
  logic [W-1:0] exp_mem_q[$];
  acc_t         exp_acc_q[$];

  logic [W-1:0] mem_model [int];
  logic [W-1:0] model_if_inst;
  logic [W-1:0] model_mem_rdata;
  bit           model_last_mem;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helpers ----------------
  task automatic chk32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string act, input string req);
    checks++;
    failures++;
    $display("FAIL %s actual=%s required=%s", name, act, req);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (bus.dbg_if_done) begin
        if (exp_if_q.size() == 0) fail_now("if_done", "pulse", "none");
        else chk32("if_inst", bus.if_inst, exp_if_q.pop_front());
      end
      if (bus.dbg_mem_done) begin
        if (exp_mem_q.size() == 0) fail_now("mem_done", "pulse", "none");
        else chk32("mem_rdata", bus.mem_rdata, exp_mem_q.pop_front());
      end
      if (bus.sram_req && bus.sram_ready) begin
        if (exp_acc_q.size() == 0) fail_now("sram_access", "access", "none");
        else begin
          acc_t e;
          e = exp_acc_q.pop_front();
          chk1("sram_we", bus.sram_we, e.we);
          chk32("sram_addr", bus.sram_addr, e.addr);
          if (e.we) chk32("sram_wdata", bus.sram_wdata, e.wdata);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.sram_we) we_cnt <= we_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit ok, output int waits);
    waits = 0;
    ok    = 1'b0;
    while (waits < 8 && !ok) begin
      step();
      waits++;
      ok = bus.sram_req;
    end
    if (!ok) fail_now("grant_wait", "no sram_req", "sram_req within 8 cycles");
  endtask

  // Access is active: hold ready low dly cycles, then answer with rd.
  // mode 1 pulses flush in the first wait cycle, mode 2 together with ready.
  task automatic serve(input int dly, input logic [W-1:0] rd, input int mode);
    for (int i = 0; i < dly; i++) begin
      bus.flush = (mode == 1 && i == 0);
      step();
    end
    bus.flush      = (mode == 2);
    bus.sram_ready = 1'b1;
    bus.sram_rdata = rd;
    step();
    bus.sram_ready = 1'b0;
    bus.flush      = 1'b0;
    bus.sram_rdata = $urandom();
  endtask

  // kind: 0 fetch, 1 data read, 2 data write
  task automatic do_txn(input int kind, input int idx, input logic [W-1:0] wdata,
                        input int dly, input bit drop_mid, input bit hold_after);
    logic [W-1:0] addr;
    logic [W-1:0] rd;
    bit           ok;
    bit           is_mem;
    int           waits;
    acc_t         e;
    addr   = W'(idx * 4);
    is_mem = (kind != 0);
    step();
    e.we    = (kind == 2);
    e.addr  = addr;
    e.wdata = wdata;
    exp_acc_q.push_back(e);
    if (kind == 2) begin
      mem_model[idx] = wdata;
      rd = $urandom();
      exp_mem_q.push_back(model_mem_rdata);
    end else begin
      rd = mem_model[idx];
      if (is_mem) begin
        model_mem_rdata = rd;
        exp_mem_q.push_back(rd);
      end else begin
        model_if_inst = rd;
        exp_if_q.push_back(rd);
      end
    end
    if (is_mem) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = (kind == 2);
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
    wait_grant(ok, waits);
    if (!ok) begin
      bus.if_req  = 1'b0;
      bus.mem_req = 1'b0;
      return;
    end
    model_last_mem = is_mem;
    chk32("grant_latency", waits, 1);
    chk1("freeze_busy", is_mem ? bus.mem_freeze : bus.if_freeze, 1'b1);
    // Inputs may wander once granted; the access must not follow them.
    bus.if_addr   = $urandom();
    bus.mem_addr  = $urandom();
    bus.mem_wdata = $urandom();
    bus.mem_we    = 1'($urandom_range(0, 1));
    if (drop_mid) begin
      bus.if_req  = 1'b0;
      bus.mem_req = 1'b0;
    end
    serve(dly, rd, 0);
    if (!drop_mid) begin
      chk1("freeze_released", is_mem ? bus.mem_freeze : bus.if_freeze, 1'b0);
      if (hold_after) begin
        step();
        chk1("no_regrant_after_done", bus.sram_req, 1'b0);
        chk1("freeze_again", is_mem ? bus.mem_freeze : bus.if_freeze, 1'b1);
      end
    end
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
  endtask

  // Both stages request in the same IDLE cycle; the one not granted last wins.
  task automatic tie_round();
    int           fi, mi, dly, waits;
    logic [W-1:0] fa, ma, rd;
    bit           ok, exp_mem;
    acc_t         e;
    fi  = $urandom_range(0, 15);
    mi  = $urandom_range(0, 15);
    dly = $urandom_range(0, 3);
    fa  = W'(fi * 4);
    ma  = 32'h0000_1000 + W'(mi * 4);
    step();
    exp_mem = !model_last_mem;
    bus.mem_wdata = $urandom();
    e.we    = 1'b0;
    e.addr  = exp_mem ? ma : fa;
    e.wdata = '0;
    exp_acc_q.push_back(e);
    rd = exp_mem ? mem_model[mi] : mem_model[fi];
    if (exp_mem) begin
      model_mem_rdata = rd;
      exp_mem_q.push_back(rd);
    end else begin
      model_if_inst = rd;
      exp_if_q.push_back(rd);
    end
    bus.if_req   = 1'b1;
    bus.if_addr  = fa;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = ma;
    wait_grant(ok, waits);
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    if (!ok) return;
    chk32("tie_winner_addr", bus.sram_addr, e.addr);
    serve(dly, rd, 0);
    model_last_mem = exp_mem;
  endtask

  // Fetch that a flush makes stale: no delivery, if_inst untouched.
  task automatic flush_txn(input int idx, input logic [W-1:0] rd, input int dly, input int mode);
    bit   ok;
    int   waits;
    acc_t e;
    step();
    e.we    = 1'b0;
    e.addr  = W'(idx * 4);
    e.wdata = '0;
    exp_acc_q.push_back(e);
    bus.if_req  = 1'b1;
    bus.if_addr = e.addr;
    bus.flush   = 1'b1;
    step();
    chk1("flush_blocks_grant", bus.sram_req, 1'b0);
    bus.flush = 1'b0;
    wait_grant(ok, waits);
    bus.if_req = 1'b0;
    if (!ok) return;
    model_last_mem = 1'b0;
    serve(dly, rd, mode);
    step();
    chk32("if_inst_kept", bus.if_inst, model_if_inst);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int waits, n, we_before;
    rst            = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.flush      = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.sram_ready = 1'b0;
    bus.sram_rdata = '0;
    model_last_mem  = 1'b0;
    model_if_inst   = '0;
    model_mem_rdata = '0;
    for (int i = 0; i < 16; i++) mem_model[i] = 32'h1000_0000 + W'(i) * 32'h0001_0111;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_sram_req", bus.sram_req, 1'b0);
    chk1("rst_sram_we", bus.sram_we, 1'b0);
    chk32("rst_sram_addr", bus.sram_addr, '0);
    chk32("rst_sram_wdata", bus.sram_wdata, '0);
    chk32("rst_if_inst", bus.if_inst, '0);
    chk32("rst_mem_rdata", bus.mem_rdata, '0);
    chk1("rst_err", bus.err, 1'b0);
    chk32("rst_state", 32'(bus.dbg_state), 32'd0);
    rst = 1'b1;

    // Ties straight out of reset: data first, then alternating.
    for (int r = 0; r < 4; r++) tie_round();

    // Single fetch of 0x10 answered one cycle after grant.
    mem_model[4] = 32'hE3A0_1005;
    do_txn(0, 4, '0, 0, 1'b0, 1'b1);
    chk32("fetch_0x10_inst", bus.if_inst, 32'hE3A0_1005);

    // Data read so mem_rdata holds something nonzero, then a write to 0x400.
    do_txn(1, 5, 32'h5555_AAAA, 1, 1'b0, 1'b0);
    we_before = we_cnt;
    do_txn(2, 256, 32'hDEAD_BEEF, 3, 1'b0, 1'b1);
    chk32("write_we_cycles", we_cnt - we_before, 4);
    chk32("write_keeps_rdata", bus.mem_rdata, model_mem_rdata);

    // Flush handling.
    mem_model[1] = 32'h0000_0001;
    do_txn(0, 1, '0, 0, 1'b0, 1'b0);
    flush_txn(2, 32'h0000_0002, 2, 1);
    flush_txn(3, 32'h0000_0003, 1, 2);

    // Random mix.
    for (int t = 0; t < 40; t++) begin
      do_txn($urandom_range(0, 2), $urandom_range(0, 15), $urandom(),
             $urandom_range(0, 4), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    // Timeout: ready never comes.
    chk1("err_before_timeout", bus.err, 1'b0);
    step();
    exp_mem_q.push_back('0);
    model_mem_rdata = '0;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h0000_0080;
    wait_grant(ok, waits);
    if (ok) begin
      model_last_mem = 1'b1;
      n = 1;
      while (n < 40) begin
        step();
        if (!bus.sram_req) break;
        n++;
      end
      chk32("timeout_cycles", n, TO);
      chk1("err_set", bus.err, 1'b1);
    end
    bus.mem_req = 1'b0;

    for (int t = 0; t < 8; t++) begin
      do_txn($urandom_range(0, 2), $urandom_range(0, 15), $urandom(),
             $urandom_range(0, 4), 1'b0, 1'b0);
    end
    chk1("err_sticky", bus.err, 1'b1);

    // Reset in the middle of a data write.
    step();
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h0000_0400;
    bus.mem_wdata = 32'hCAFE_F00D;
    wait_grant(ok, waits);
    chk1("pre_reset_we", bus.sram_we, 1'b1);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk1("async_rst_sram_req", bus.sram_req, 1'b0);
    chk1("async_rst_sram_we", bus.sram_we, 1'b0);
    chk32("async_rst_sram_addr", bus.sram_addr, '0);
    chk32("async_rst_sram_wdata", bus.sram_wdata, '0);
    chk32("async_rst_if_inst", bus.if_inst, '0);
    chk32("async_rst_mem_rdata", bus.mem_rdata, '0);
    chk1("async_rst_err", bus.err, 1'b0);
    chk32("async_rst_state", 32'(bus.dbg_state), 32'd0);
    bus.mem_req = 1'b0;
    step();
    rst = 1'b1;
    repeat (3) step();

    chk32("pending_fetch_results", exp_if_q.size(), 0);
    chk32("pending_data_results", exp_mem_q.size(), 0);
    chk32("pending_sram_accesses", exp_acc_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=still_running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_mem_arbiter.md
FETCH_MEM_ARBITER -- requirements
Module: fetch_mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data and address width in bits.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles an access may wait for sram_ready before abort; legal range 1..255.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  fetch stage requests an instruction read.
REQ-006 if_addr  in  DATA_W  fetch byte address (PC).
REQ-007 flush  in  1  branch taken; cancels any in-flight fetch.
REQ-008 mem_req  in  1  memory stage requests a data access.
REQ-009 mem_we  in  1  1 = write, 0 = read.
REQ-010 mem_addr  in  DATA_W  data byte address.
REQ-011 mem_wdata  in  DATA_W  write data.
REQ-012 sram_ready  in  1  shared memory completes current access this cycle.
REQ-013 sram_rdata  in  DATA_W  shared memory read data, valid when sram_ready=1.
REQ-014 sram_req  out  1  access active toward shared memory.
REQ-015 sram_we  out  1  write strobe toward shared memory.
REQ-016 sram_addr  out  DATA_W  access address.
REQ-017 sram_wdata  out  DATA_W  write data.
REQ-018 if_inst  out  DATA_W  fetched instruction, held until next fetch delivery.
REQ-019 if_freeze  out  1  fetch stage must hold PC.
REQ-020 mem_rdata  out  DATA_W  read data, held until next data delivery.
REQ-021 mem_freeze  out  1  memory stage must stall.
REQ-022 err  out  1  sticky timeout flag.

Function
REQ-023 FSM states SHALL be IDLE, IF_ACC, MEM_ACC; one access outstanding at a time.
REQ-024 IDLE, only mem_req: go MEM_ACC; only if_req (and flush=0): go IF_ACC; neither: stay.
REQ-025 IDLE, both requesting: grant the requester not granted last (last_grant register, reset value = fetch, so data wins first tie).
REQ-026 On grant, address, we and wdata SHALL be latched; sram_addr/sram_we/sram_wdata driven from latches, stable until completion regardless of input changes.
REQ-027 sram_req=1 exactly while in IF_ACC or MEM_ACC; sram_we=0 in IF_ACC.
REQ-028 Completion: sram_ready=1 in an access state; next state IDLE; read data captured into if_inst (IF_ACC) or mem_rdata (MEM_ACC, read only; writes leave mem_rdata unchanged).
REQ-029 Registered one-cycle done pulse (if_done / mem_done) SHALL assert the cycle after completion.
REQ-030 if_freeze = if_req AND NOT if_done; mem_freeze = mem_req AND NOT mem_done (combinational).
REQ-031 Minimum latency: request seen in IDLE cycle N, sram_ready=1 in N+1, freeze low in N+2.
REQ-032 Cycle-count register SHALL clear on entry to an access state and increment each cycle sram_ready=0.
REQ-033 Count reaching TIMEOUT: abort to IDLE, set err, deliver done pulse with captured data 0.
REQ-034 err SHALL remain 1 until reset.
REQ-035 flush in IF_ACC SHALL set a discard flag; that fetch completes normally toward memory but produces no if_done and leaves if_inst unchanged.
REQ-036 flush and sram_ready both high in IF_ACC: result discarded.
REQ-037 flush in IDLE SHALL block a new fetch grant that cycle; flush has no effect on MEM_ACC.
REQ-038 Requester dropping its request mid-access: access completes, done pulse still issued, freeze unaffected since req=0.
REQ-039 No new grant in the cycle following completion while its done pulse is high for that requester (prevents re-fetch of same PC).

Reset
REQ-040 rst=0 SHALL immediately force IDLE, sram_req=0, sram_we=0, sram_addr=0, sram_wdata=0, if_inst=0, mem_rdata=0, done pulses=0, discard=0, counter=0, err=0, last_grant=fetch.
REQ-041 Reset mid-access SHALL abandon the access without delivering data.

Verification
REQ-042 if_req=1, if_addr=0x10, sram_ready high 1 cycle after grant with rdata 0xE3A01005 -> sram_addr=0x10, if_inst=0xE3A01005, if_freeze low exactly 1 cycle.
REQ-043 if_req and mem_req both 1 from reset -> MEM_ACC first, then IF_ACC; repeat tie -> alternates.
REQ-044 mem write, addr 0x400, wdata 0xDEADBEEF, ready after 3 cycles -> sram_we=1 for 4 cycles, mem_rdata unchanged, mem_freeze low 1 cycle after completion.
REQ-045 flush pulsed during IF_ACC with if_inst=0x1 prior, rdata 0x2 -> no if_done, if_inst stays 0x1.
REQ-046 TIMEOUT=15, sram_ready held 0 -> abort after 15 cycles, err=1 sticky, delivered data 0.
REQ-047 rst asserted mid MEM_ACC -> sram_req drops same cycle (asynchronous), all outputs at reset values.
